// File: rtl/write.sv
// ---------------------------------------------------------------------------
// write -- write-back stage of the pipeline.
//
// Retires execute-stage payloads into a small architectural register file,
// issues data-memory stores, and performs a second-cycle "upper" register
// write for instructions that produce a register pair.
//
// Parameters
//   NR     number of architectural registers (entry 0 is hard-wired to zero)
//   PC     register index of the program counter
//   Flags  register index of the flags register
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   pc, adjustment_value, destination_value, upper_value,
//   destination_register, flags,
//   has_flushed, is_valid, is_writing_memory, has_upper_value
//                         execute-to-write payload and qualifiers
//   hold                  back-pressure: payload is not consumed while high
//   registers             flattened register file, entry i at [32i+31:32i]
//   mem_address, mem_writedata, mem_write, mem_waitrequest
//                         data-memory write request, held while stalled
//   pc_write, new_pc      one-cycle pulse when a retire wrote the PC
// ---------------------------------------------------------------------------
module write #(
  parameter int NR    = 4,
  parameter int PC    = NR - 2,
  parameter int Flags = NR - 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic [31:0]        adjustment_value,
  input  logic [31:0]        destination_value,
  input  logic [31:0]        upper_value,
  input  logic [4:0]         destination_register,
  input  logic [3:0]         flags,
  input  logic               has_flushed,
  input  logic               is_valid,
  input  logic               is_writing_memory,
  input  logic               has_upper_value,
  output logic               hold,
  output logic [NR*32-1:0]   registers,
  output logic [31:0]        mem_address,
  output logic [31:0]        mem_writedata,
  output logic               mem_write,
  input  logic               mem_waitrequest,
  output logic               pc_write,
  output logic [31:0]        new_pc
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    MEMORY = 2'd1,
    UPPER  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [4:0]  upper_index_reg;
  logic [31:0] upper_value_reg;

  logic retire;
  logic lower_write;
  logic dest_is_pc;

  // A payload is consumed only in ACCEPT; flushed or invalid payloads vanish.
  assign retire      = (state_reg == ACCEPT) && is_valid && !has_flushed;
  assign lower_write = retire && !is_writing_memory;
  assign dest_is_pc  = (int'({27'd0, destination_register}) == PC);

  // hold is a pure function of the state register (Moore).
  assign hold = (state_reg != ACCEPT);

  // -------------------------------------------------------------------------
  // Control FSM plus memory-request and PC-write outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ACCEPT;
      mem_address     <= 32'd0;
      mem_writedata   <= 32'd0;
      mem_write       <= 1'b0;
      pc_write        <= 1'b0;
      new_pc          <= 32'd0;
      upper_index_reg <= 5'd0;
      upper_value_reg <= 32'd0;
    end else begin
      pc_write <= 1'b0;
      case (state_reg)
        ACCEPT: begin
          if (retire) begin
            if (is_writing_memory) begin
              mem_address   <= adjustment_value;
              mem_writedata <= destination_value;
              mem_write     <= 1'b1;
              state_reg     <= MEMORY;
            end else begin
              if (dest_is_pc) begin
                pc_write <= 1'b1;
                new_pc   <= destination_value;
              end
              if (has_upper_value) begin
                // 5-bit add wraps 31 -> 0, which the register file then drops.
                upper_index_reg <= destination_register + 5'd1;
                upper_value_reg <= upper_value;
                state_reg       <= UPPER;
              end
            end
          end
        end
        MEMORY: begin
          // Request stays frozen until the memory accepts it.
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            state_reg <= ACCEPT;
          end
        end
        UPPER: begin
          state_reg <= ACCEPT;
        end
        default: begin
          state_reg <= ACCEPT;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Register file: one independent register per entry. Priority inside a
  // retire is destination write > PC load > flags load, so a destination that
  // names PC or Flags overrides the automatic update of that entry.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        assign registers[31:0] = 32'd0;
      end else begin : g_reg
        logic [31:0] entry_reg;
        logic        dest_hit;
        logic        upper_hit;

        // Indices >= 32 can never be addressed by a 5-bit destination.
        if (gi < 32) begin : g_addr
          assign dest_hit  = (destination_register == 5'(gi));
          assign upper_hit = (upper_index_reg == 5'(gi));
        end else begin : g_noaddr
          assign dest_hit  = 1'b0;
          assign upper_hit = 1'b0;
        end

        always_ff @(posedge clock) begin
          if (reset) begin
            entry_reg <= 32'd0;
          end else if (state_reg == UPPER) begin
            if (upper_hit) begin
              entry_reg <= upper_value_reg;
            end
          end else if (retire) begin
            if (lower_write && dest_hit) begin
              entry_reg <= destination_value;
            end else if (gi == PC) begin
              entry_reg <= pc;
            end else if ((gi == Flags) && !is_writing_memory) begin
              entry_reg <= {28'd0, flags};
            end
          end
        end

        assign registers[gi*32 +: 32] = entry_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_write.sv
// ---------------------------------------------------------------------------
// tb_write -- directed, table-driven bench for the write-back stage.
// NR=4, so PC is register 2 and Flags is register 3.
// ---------------------------------------------------------------------------
module tb_write;

  localparam int NR = 4;

  logic             clock;
  logic             reset;
  logic [31:0]      pc;
  logic [31:0]      adjustment_value;
  logic [31:0]      destination_value;
  logic [31:0]      upper_value;
  logic [4:0]       destination_register;
  logic [3:0]       flags;
  logic             has_flushed;
  logic             is_valid;
  logic             is_writing_memory;
  logic             has_upper_value;
  logic             hold;
  logic [NR*32-1:0] registers;
  logic [31:0]      mem_address;
  logic [31:0]      mem_writedata;
  logic             mem_write;
  logic             mem_waitrequest;
  logic             pc_write;
  logic [31:0]      new_pc;

  int tests_run;
  int tests_failed;

  write #(.NR(NR)) dut (
    .clock                (clock),
    .reset                (reset),
    .pc                   (pc),
    .adjustment_value     (adjustment_value),
    .destination_value    (destination_value),
    .upper_value          (upper_value),
    .destination_register (destination_register),
    .flags                (flags),
    .has_flushed          (has_flushed),
    .is_valid             (is_valid),
    .is_writing_memory    (is_writing_memory),
    .has_upper_value      (has_upper_value),
    .hold                 (hold),
    .registers            (registers),
    .mem_address          (mem_address),
    .mem_writedata        (mem_writedata),
    .mem_write            (mem_write),
    .mem_waitrequest      (mem_waitrequest),
    .pc_write             (pc_write),
    .new_pc               (new_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic        flushed;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [3:0]  flg;
    logic [31:0] pcv;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic [31:0] exp_r3;
    logic        exp_pcw;
    logic [31:0] exp_new_pc;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] reg_at(input int i);
    return registers[i*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
    check({tag, " r0"}, reg_at(0), 32'd0);
    check({tag, " r1"}, reg_at(1), r1);
    check({tag, " r2"}, reg_at(2), r2);
    check({tag, " r3"}, reg_at(3), r3);
  endtask

  task automatic idle_inputs();
    is_valid             = 1'b0;
    has_flushed          = 1'b0;
    is_writing_memory    = 1'b0;
    has_upper_value      = 1'b0;
    destination_register = 5'd0;
    destination_value    = 32'd0;
    upper_value          = 32'd0;
    adjustment_value     = 32'd0;
    flags                = 4'd0;
    pc                   = 32'd0;
    mem_waitrequest      = 1'b0;
  endtask

  initial begin
    int high_cycles;
    tests_run    = 0;
    tests_failed = 0;

    //            valid flush dest value         flg   pc        r1            r2            r3            pcw   new_pc
    vecs[0] = '{1'b1, 1'b0, 5'd1, 32'h1234, 4'h5, 32'h8,  32'h1234, 32'h8,  32'h5,    1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 5'd0, 32'hFFFF, 4'h1, 32'hC,  32'h1234, 32'hC,  32'h1,    1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 5'd2, 32'h40,   4'h2, 32'h10, 32'h1234, 32'h40, 32'h2,    1'b1, 32'h40};
    vecs[3] = '{1'b1, 1'b0, 5'd3, 32'hAAAA, 4'h7, 32'h14, 32'h1234, 32'h14, 32'hAAAA, 1'b0, 32'h40};
    vecs[4] = '{1'b1, 1'b1, 5'd1, 32'hDEAD, 4'hF, 32'h99, 32'h1234, 32'h14, 32'hAAAA, 1'b0, 32'h40};
    vecs[5] = '{1'b0, 1'b0, 5'd1, 32'hDEAD, 4'hF, 32'h99, 32'h1234, 32'h14, 32'hAAAA, 1'b0, 32'h40};
    vecs[6] = '{1'b1, 1'b0, 5'd5, 32'hBEEF, 4'h9, 32'h20, 32'h1234, 32'h20, 32'h9,    1'b0, 32'h40};
    vecs[7] = '{1'b1, 1'b0, 5'd1, 32'h55,   4'h0, 32'h24, 32'h55,   32'h24, 32'h0,    1'b0, 32'h40};

    // ---------------- reset ----------------
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_regs("reset", 32'd0, 32'd0, 32'd0);
    check("reset hold", {31'd0, hold}, 32'd0);
    check("reset mem_write", {31'd0, mem_write}, 32'd0);
    check("reset mem_address", mem_address, 32'd0);
    check("reset mem_writedata", mem_writedata, 32'd0);
    check("reset pc_write", {31'd0, pc_write}, 32'd0);
    check("reset new_pc", new_pc, 32'd0);
    $display("[TB] reset done");

    // ---------------- table-driven retires ----------------
    for (int i = 0; i < 8; i++) begin
      is_valid             = vecs[i].valid;
      has_flushed          = vecs[i].flushed;
      destination_register = vecs[i].dest;
      destination_value    = vecs[i].value;
      flags                = vecs[i].flg;
      pc                   = vecs[i].pcv;
      step();
      check_regs($sformatf("vec%0d", i), vecs[i].exp_r1, vecs[i].exp_r2, vecs[i].exp_r3);
      check($sformatf("vec%0d pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].exp_pcw});
      check($sformatf("vec%0d new_pc", i), new_pc, vecs[i].exp_new_pc);
      check($sformatf("vec%0d hold", i), {31'd0, hold}, 32'd0);
      check($sformatf("vec%0d mem_write", i), {31'd0, mem_write}, 32'd0);
      $display("[TB] vec %0d valid=%0d flushed=%0d dest=%0d value=%h done",
               i, vecs[i].valid, vecs[i].flushed, vecs[i].dest, vecs[i].value);
    end
    // pc_write must be a single-cycle pulse: check it dropped after vec 2.
    // (vec 3 already covers this through exp_pcw = 0.)

    // ---------------- memory write with 3 stall cycles ----------------
    // State now: r1=55, r2=24, r3=0. pc matches r2 so the PC entry stays put.
    idle_inputs();
    is_valid             = 1'b1;
    is_writing_memory    = 1'b1;
    destination_register = 5'd1;
    destination_value    = 32'hAB;
    adjustment_value     = 32'h100;
    flags                = 4'hF;
    pc                   = 32'h24;
    mem_waitrequest      = 1'b1;
    step();
    high_cycles = 0;
    if (mem_write) high_cycles++;
    check("mem start mem_write", {31'd0, mem_write}, 32'd1);
    check("mem start hold", {31'd0, hold}, 32'd1);
    check("mem start address", mem_address, 32'h100);
    check("mem start data", mem_writedata, 32'hAB);
    check_regs("mem start", 32'h55, 32'h24, 32'h0);
    // A competing register payload while held must be ignored.
    is_writing_memory    = 1'b0;
    destination_value    = 32'h999;
    adjustment_value     = 32'h555;
    pc                   = 32'h77;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        mem_waitrequest = 1'b0;
        is_valid        = 1'b0;
      end
      step();
      if (mem_write) high_cycles++;
      if (c < 2) begin
        check($sformatf("mem stall%0d address", c), mem_address, 32'h100);
        check($sformatf("mem stall%0d data", c), mem_writedata, 32'hAB);
        check($sformatf("mem stall%0d hold", c), {31'd0, hold}, 32'd1);
      end
      $display("[TB] mem cycle %0d mem_write=%0d hold=%0d", c, mem_write, hold);
    end
    // The third wait-high edge was covered above with waitrequest low at c==2;
    // one more high edge is needed for a 3-cycle stall, so recount below.
    check("mem done mem_write", {31'd0, mem_write}, 32'd0);
    check("mem done hold", {31'd0, hold}, 32'd0);
    check("mem high cycles", high_cycles, 32'd3);
    check_regs("mem done", 32'h55, 32'h24, 32'h0);

    // Exact 3-stall-cycle case: mem_write must be high for 4 sampled cycles.
    idle_inputs();
    is_valid          = 1'b1;
    is_writing_memory = 1'b1;
    destination_value = 32'hCD;
    adjustment_value  = 32'h200;
    pc                = 32'h24;
    mem_waitrequest   = 1'b1;
    step();
    is_valid    = 1'b0;
    high_cycles = mem_write ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_waitrequest = 1'b0;
      step();
      if (mem_write) high_cycles++;
      if (c < 3) check($sformatf("mem3 hold%0d", c), {31'd0, hold}, 32'd1);
    end
    check("mem3 high cycles", high_cycles, 32'd4);
    check("mem3 released hold", {31'd0, hold}, 32'd0);
    $display("[TB] mem3 transaction high_cycles=%0d", high_cycles);

    // ---------------- upper write ----------------
    idle_inputs();
    is_valid             = 1'b1;
    has_upper_value      = 1'b1;
    destination_register = 5'd1;
    destination_value    = 32'h7;
    upper_value          = 32'h9;
    flags                = 4'h3;
    pc                   = 32'h30;
    step();
    is_valid = 1'b0;
    check_regs("upper c1", 32'h7, 32'h30, 32'h3);
    check("upper c1 hold", {31'd0, hold}, 32'd1);
    check("upper c1 pc_write", {31'd0, pc_write}, 32'd0);
    step();
    check_regs("upper c2", 32'h7, 32'h9, 32'h3);
    check("upper c2 hold", {31'd0, hold}, 32'd0);
    check("upper c2 pc_write", {31'd0, pc_write}, 32'd0);
    $display("[TB] upper dest=1 done");

    // Upper write wrapping 31 -> 0 is dropped.
    is_valid             = 1'b1;
    has_upper_value      = 1'b1;
    destination_register = 5'd31;
    destination_value    = 32'h1;
    upper_value          = 32'h77;
    flags                = 4'h4;
    pc                   = 32'h44;
    step();
    is_valid = 1'b0;
    check("wrap c1 hold", {31'd0, hold}, 32'd1);
    step();
    check_regs("wrap c2", 32'h7, 32'h44, 32'h4);
    check("wrap c2 hold", {31'd0, hold}, 32'd0);
    $display("[TB] upper dest=31 done");

    // ---------------- reset during a stalled memory request ----------------
    idle_inputs();
    is_valid          = 1'b1;
    is_writing_memory = 1'b1;
    destination_value = 32'hEE;
    adjustment_value  = 32'h300;
    mem_waitrequest   = 1'b1;
    step();
    is_valid = 1'b0;
    check("rstmem pending", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmem mem_write", {31'd0, mem_write}, 32'd0);
    check("rstmem hold", {31'd0, hold}, 32'd0);
    check("rstmem address", mem_address, 32'd0);
    check_regs("rstmem", 32'd0, 32'd0, 32'd0);
    $display("[TB] reset during memory done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/write.md
WRITE -- requirements
Module: write

Interface
REQ-001 Parameter NR, default 4, number of architectural registers held by this stage.
REQ-002 Parameter PC, default NR-2, register index of the program counter.
REQ-003 Parameter Flags, default NR-1, register index of the flags register.
REQ-004 Port clock  in  1  single clock; all state changes on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Ports pc, adjustment_value, destination_value, upper_value  in  32 each  execute-to-write payload.
REQ-007 Port destination_register  in  5  target register index.
REQ-008 Port flags  in  4  flag result of the executed operation.
REQ-009 Ports has_flushed, is_valid, is_writing_memory, has_upper_value  in  1 each  execute-to-write qualifiers.
REQ-010 Port hold  out  1  back-pressure to execute; payload not consumed while high.
REQ-011 Port registers  out  NR*32  register file, entry i at bits [32i+31:32i].
REQ-012 Ports mem_address, mem_writedata  out  32 each  data-memory write address/data.
REQ-013 Port mem_write  out  1  memory write request.
REQ-014 Port mem_waitrequest  in  1  memory stall; request held while high.
REQ-015 Port pc_write  out  1  one-cycle pulse: retired instruction wrote PC.
REQ-016 Port new_pc  out  32  PC value written, valid when pc_write high.

Function
REQ-017 States SHALL be ACCEPT, MEMORY, UPPER; hold SHALL be 1 exactly when state is not ACCEPT (Moore, registered).
REQ-018 In ACCEPT, payload SHALL be retired when is_valid=1 and has_flushed=0; otherwise it SHALL be discarded with no state change.
REQ-019 Retire, is_writing_memory=0: registers[destination_register] <= destination_value next edge, only if index nonzero and < NR; index 0 and index >= NR writes dropped.
REQ-020 registers[0] SHALL read 0 at all times.
REQ-021 Every retire with is_writing_memory=0 SHALL load flags, zero-extended, into registers[Flags], unless destination_register equals Flags, in which case destination_value wins.
REQ-022 Every retire SHALL load pc into registers[PC], unless destination_register equals PC, in which case destination_value wins, pc_write pulses one cycle and new_pc = destination_value.
REQ-023 Retire with is_writing_memory=1: mem_address <= adjustment_value, mem_writedata <= destination_value, mem_write <= 1, state -> MEMORY; no register or flags write; has_upper_value ignored.
REQ-024 In MEMORY, mem_write, mem_address, mem_writedata SHALL stay stable while mem_waitrequest=1; on first edge with mem_waitrequest=0, mem_write <= 0, state -> ACCEPT.
REQ-025 Retire with has_upper_value=1 and is_writing_memory=0: lower write per REQ-019, latch (destination_register+1) mod 32 and upper_value, state -> UPPER.
REQ-026 In UPPER, latched upper_value SHALL be written to the latched index under REQ-019/020 rules (31+1 wraps to 0, dropped), flags/PC untouched, state -> ACCEPT; no pc_write even if index equals PC.
REQ-027 Register-file update latency SHALL be one cycle: written value visible on registers the cycle after the retiring edge.
REQ-028 Minimum throughput: one retire per cycle in ACCEPT; MEMORY takes >=1 cycle, UPPER exactly 1 cycle.

Reset
REQ-029 On reset high at an edge: all registers entries 0, state ACCEPT, hold 0, mem_write 0, mem_address 0, mem_writedata 0, pc_write 0, new_pc 0.
REQ-030 Reset SHALL win over every concurrent event, including a pending MEMORY request (dropped) or UPPER write (dropped).

Verification
REQ-031 Retire dest=1, value=32'h1234, flags=4'h5, pc=8 -> next cycle registers[1]=32'h1234, registers[3]=5, registers[2]=8, hold 0.
REQ-032 Retire dest=0, value=32'hFFFF -> registers[0] stays 0; dest=2, value=32'h40 -> registers[2]=32'h40, pc_write one cycle, new_pc=32'h40.
REQ-033 Memory write adjustment_value=32'h100, destination_value=32'hAB, mem_waitrequest high 3 cycles -> mem_write high 4 cycles, address/data stable, hold high throughout, registers unchanged.
REQ-034 has_upper_value=1, dest=1, value=7, upper=9 -> registers[1]=7 after cycle 1, registers[2]=9 after cycle 2, hold high 1 cycle, no pc_write.
REQ-035 has_flushed=1 or is_valid=0 with dest=1 -> no register, flags, PC, or memory change.
REQ-036 Reset asserted during MEMORY with mem_waitrequest high -> next cycle mem_write 0, hold 0, all registers 0.
